// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the serial sequence detectors.
// Holds the detector state encoding and the pattern-length clamp.
package seq_det_pkg;

    localparam int DEFAULT_MAX_LEN = 16;
    localparam int DEFAULT_CNT_W   = 8;

    typedef enum logic [1:0] {
        UNCONF  = 2'd0,
        FILLING = 2'd1,
        ARMED   = 2'd2
    } det_state_t;

    // A zero length means "one bit"; anything beyond the history depth saturates.
    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned max_len);
        int unsigned res;
        if (len == 0)
            res = 1;
        else if (len > max_len)
            res = max_len;
        else
            res = len;
        return res;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// A clear together with an increment leaves the count at one.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= inc ? W'(1) : '0;
        else if (inc && (count != {W{1'b1}}))
            count <= count + W'(1);
    end

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-programmable serial pattern detector with a registered match pulse,
// optional overlapping matches and a saturating match counter.
module seq_detect_param
    import seq_det_pkg::*;
#(
    parameter  int MAX_LEN = DEFAULT_MAX_LEN,
    parameter  int CNT_W   = DEFAULT_CNT_W,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               din,
    input  logic               din_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               flag,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               armed
);

    det_state_t         state, state_next;
    logic [MAX_LEN-1:0] history, history_next;
    logic [MAX_LEN-1:0] pat_reg, pat_next;
    logic [LEN_W-1:0]   fill, fill_next;
    logic [LEN_W-1:0]   len_reg, len_next;
    logic               ovl_reg, ovl_next;
    logic               flag_next;

    logic [MAX_LEN-1:0] cand;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W:0]     fill_plus;
    logic [LEN_W-1:0]   fill_sat;
    logic               reach;
    logic               match;

    // The candidate window already includes the incoming bit, so a match is
    // detected on the very sample that completes the pattern.
    always_comb begin
        cand      = {history[MAX_LEN-2:0], din};
        mask      = '0;
        for (int i = 0; i < MAX_LEN; i++)
            mask[i] = (i < int'(len_reg));
        fill_plus = {1'b0, fill} + (LEN_W + 1)'(1);
        fill_sat  = (fill_plus > (LEN_W + 1)'(MAX_LEN)) ? LEN_W'(MAX_LEN)
                                                        : fill_plus[LEN_W-1:0];
        reach     = (fill_plus >= {1'b0, len_reg});
        match     = din_valid && !cfg_load && (state != UNCONF) && reach &&
                    ((cand & mask) == (pat_reg & mask));
    end

    always_comb begin
        state_next   = state;
        history_next = history;
        fill_next    = fill;
        pat_next     = pat_reg;
        len_next     = len_reg;
        ovl_next     = ovl_reg;
        flag_next    = 1'b0;

        if (cfg_load) begin
            pat_next     = cfg_pattern;
            len_next     = LEN_W'(clamp_len(32'(cfg_len), MAX_LEN));
            ovl_next     = cfg_overlap;
            fill_next    = '0;
            history_next = '0;
            state_next   = FILLING;
        end else begin
            case (state)
                UNCONF: begin
                    state_next = UNCONF;
                end
                FILLING, ARMED: begin
                    if (din_valid) begin
                        history_next = cand;
                        fill_next    = fill_sat;
                        // Without overlap, clearing fill hides the bits that formed this match.
                        if (match) begin
                            flag_next = 1'b1;
                            if (!ovl_reg) begin
                                fill_next  = '0;
                                state_next = FILLING;
                            end else begin
                                state_next = ARMED;
                            end
                        end else if (reach) begin
                            state_next = ARMED;
                        end
                    end
                end
                default: begin
                    state_next = UNCONF;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= UNCONF;
            history <= '0;
            fill    <= '0;
            pat_reg <= '0;
            len_reg <= LEN_W'(1);
            ovl_reg <= 1'b1;
            flag    <= 1'b0;
            armed   <= 1'b0;
        end else begin
            state   <= state_next;
            history <= history_next;
            fill    <= fill_next;
            pat_reg <= pat_next;
            len_reg <= len_next;
            ovl_reg <= ovl_next;
            flag    <= flag_next;
            armed   <= (state_next == ARMED);
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (match),
        .clr  (cnt_clr),
        .count(match_cnt)
    );

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed self-checking bench for seq_detect_param: a default-sized instance
// plus a narrow-counter instance used for saturation.
module tb_seq_detect_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        din = 1'b0, din_valid = 1'b0, cfg_load = 1'b0;
    logic [15:0] cfg_pattern = '0;
    logic [4:0]  cfg_len = '0;
    logic        cfg_overlap = 1'b0, cnt_clr = 1'b0;
    logic        flag, armed;
    logic [7:0]  match_cnt;

    logic        s_din = 1'b0, s_din_valid = 1'b0, s_cfg_load = 1'b0;
    logic [3:0]  s_cfg_pattern = '0;
    logic [2:0]  s_cfg_len = '0;
    logic        s_cfg_overlap = 1'b0, s_cnt_clr = 1'b0;
    logic        s_flag, s_armed;
    logic [1:0]  s_match_cnt;

    int checks = 0;
    int errors = 0;

    seq_detect_param #(.MAX_LEN(16), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .flag(flag), .match_cnt(match_cnt), .armed(armed)
    );

    seq_detect_param #(.MAX_LEN(4), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .din(s_din), .din_valid(s_din_valid),
        .cfg_load(s_cfg_load), .cfg_pattern(s_cfg_pattern), .cfg_len(s_cfg_len),
        .cfg_overlap(s_cfg_overlap), .cnt_clr(s_cnt_clr),
        .flag(s_flag), .match_cnt(s_match_cnt), .armed(s_armed)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic step(input logic d, input logic v);
        @(negedge clk);
        din = d; din_valid = v; cfg_load = 1'b0; cnt_clr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic configure(input logic [15:0] pat, input logic [4:0] len,
                             input logic ovl, input logic d, input logic v);
        @(negedge clk);
        cfg_load = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
        din = d; din_valid = v; cnt_clr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cnt();
        @(negedge clk);
        cnt_clr = 1'b1; din_valid = 1'b0; cfg_load = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic s_step(input logic d, input logic v, input logic clr);
        @(negedge clk);
        s_din = d; s_din_valid = v; s_cfg_load = 1'b0; s_cnt_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (flag !== 1'b0 || armed !== 1'b0 || match_cnt !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_main: flag=%b armed=%b cnt=%0d expected 0/0/0", flag, armed, match_cnt);
        end
        checks++;
        if (s_flag !== 1'b0 || s_armed !== 1'b0 || s_match_cnt !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_small: flag=%b armed=%b cnt=%0d expected 0/0/0", s_flag, s_armed, s_match_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_unconfigured();
        for (int i = 0; i < 10; i++) begin
            step(logic'(i % 2), 1'b1);
            checks++;
            if (flag !== 1'b0) begin
                errors++;
                $display("[TB] FAIL unconf_flag[%0d]: got %b expected 0", i, flag);
            end
        end
        checks++;
        if (match_cnt !== 8'd0 || armed !== 1'b0) begin
            errors++;
            $display("[TB] FAIL unconf_cnt: cnt=%0d armed=%b expected 0/0", match_cnt, armed);
        end
    endtask

    task automatic test_overlap();
        logic exp_flag;
        configure(16'h0055, 5'd8, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(logic'(i % 2), 1'b1);
            exp_flag = (i == 7) || (i == 9);
            checks++;
            if (flag !== exp_flag) begin
                errors++;
                $display("[TB] FAIL ovl_flag[%0d]: got %b expected %b", i, flag, exp_flag);
            end
            if (i == 5 || i == 7) begin
                checks++;
                if (armed !== (i == 7)) begin
                    errors++;
                    $display("[TB] FAIL ovl_armed[%0d]: got %b expected %b", i, armed, (i == 7));
                end
            end
        end
        checks++;
        if (match_cnt !== 8'd2) begin
            errors++;
            $display("[TB] FAIL ovl_cnt: got %0d expected 2", match_cnt);
        end
    endtask

    task automatic test_non_overlap();
        logic exp_flag;
        clear_cnt();
        configure(16'h0055, 5'd8, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(logic'(i % 2), 1'b1);
            exp_flag = (i == 7);
            checks++;
            if (flag !== exp_flag) begin
                errors++;
                $display("[TB] FAIL novl_flag[%0d]: got %b expected %b", i, flag, exp_flag);
            end
            if (i >= 7) begin
                checks++;
                if (armed !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL novl_armed[%0d]: got %b expected 0", i, armed);
                end
            end
        end
        checks++;
        if (match_cnt !== 8'd1) begin
            errors++;
            $display("[TB] FAIL novl_cnt: got %0d expected 1", match_cnt);
        end
    endtask

    task automatic test_gaps();
        logic [1:0] vec [5] = '{2'b11, 2'b01, 2'b10, 2'b10, 2'b11};
        logic       exp [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        clear_cnt();
        configure(16'h0005, 5'd3, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(vec[i][1], vec[i][0]);
            checks++;
            if (flag !== exp[i]) begin
                errors++;
                $display("[TB] FAIL gap_flag[%0d]: got %b expected %b", i, flag, exp[i]);
            end
        end
        checks++;
        if (match_cnt !== 8'd1) begin
            errors++;
            $display("[TB] FAIL gap_cnt: got %0d expected 1", match_cnt);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt;
        @(negedge clk);
        s_cfg_load = 1'b1; s_cfg_pattern = 4'b0001; s_cfg_len = 3'd1; s_cfg_overlap = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            s_step(1'b1, 1'b1, 1'b0);
            exp_cnt = (i >= 2) ? 2'd3 : 2'(i + 1);
            checks++;
            if (s_flag !== 1'b1 || s_match_cnt !== exp_cnt) begin
                errors++;
                $display("[TB] FAIL sat[%0d]: flag=%b cnt=%0d expected 1/%0d", i, s_flag, s_match_cnt, exp_cnt);
            end
        end
        s_step(1'b1, 1'b1, 1'b1);
        checks++;
        if (s_flag !== 1'b1 || s_match_cnt !== 2'd1) begin
            errors++;
            $display("[TB] FAIL clr_with_match: flag=%b cnt=%0d expected 1/1", s_flag, s_match_cnt);
        end
        s_step(1'b0, 1'b0, 1'b1);
        checks++;
        if (s_flag !== 1'b0 || s_match_cnt !== 2'd0) begin
            errors++;
            $display("[TB] FAIL clr_alone: flag=%b cnt=%0d expected 0/0", s_flag, s_match_cnt);
        end
    endtask

    task automatic test_len_clamp();
        configure(16'h0001, 5'd0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1);
        checks++;
        if (flag !== 1'b1) begin
            errors++;
            $display("[TB] FAIL len0_hit: got %b expected 1", flag);
        end
        step(1'b0, 1'b1);
        checks++;
        if (flag !== 1'b0) begin
            errors++;
            $display("[TB] FAIL len0_miss: got %b expected 0", flag);
        end
        configure(16'hFFFF, 5'd31, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b1);
            if (i >= 14) begin
                checks++;
                if (flag !== (i == 15)) begin
                    errors++;
                    $display("[TB] FAIL lenmax_flag[%0d]: got %b expected %b", i, flag, (i == 15));
                end
            end
        end
    endtask

    task automatic test_cfg_abort_and_reset();
        logic seq [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        clear_cnt();
        configure(16'h000D, 5'd4, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step(seq[i], 1'b1);
        configure(16'h000D, 5'd4, 1'b1, 1'b1, 1'b1);
        checks++;
        if (flag !== 1'b0 || match_cnt !== 8'd0) begin
            errors++;
            $display("[TB] FAIL abort_drop: flag=%b cnt=%0d expected 0/0", flag, match_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            step(seq[i], 1'b1);
            checks++;
            if (flag !== (i == 3)) begin
                errors++;
                $display("[TB] FAIL abort_flag[%0d]: got %b expected %b", i, flag, (i == 3));
            end
        end
        checks++;
        if (armed !== 1'b1 || match_cnt !== 8'd1) begin
            errors++;
            $display("[TB] FAIL abort_post: armed=%b cnt=%0d expected 1/1", armed, match_cnt);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (flag !== 1'b0 || armed !== 1'b0 || match_cnt !== 8'd0) begin
            errors++;
            $display("[TB] FAIL async_rst: flag=%b armed=%b cnt=%0d expected 0/0/0", flag, armed, match_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(seq[i], 1'b1);
            checks++;
            if (flag !== 1'b0) begin
                errors++;
                $display("[TB] FAIL post_rst_flag[%0d]: got %b expected 0", i, flag);
            end
        end
    endtask

    initial begin
        $display("[TB] starting seq_detect_param bench");
        test_reset();
        test_unconfigured();
        test_overlap();
        test_non_overlap();
        test_gaps();
        test_saturation();
        test_len_clamp();
        test_cfg_abort_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
